// File: rtl/core_bus_pkg.sv
// core_bus_pkg: shared types and constants for the core bus arbiter
package core_bus_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, ABORT} arb_state_t;
  localparam int MAX_MASTERS = 4;
  localparam int MIDX_W = $clog2(MAX_MASTERS);
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past the last winner
module rr_arbiter
  import core_bus_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]      req_i,
  input  logic [MIDX_W-1:0] last_i,
  output logic [N-1:0]      gnt_o,
  output logic [MIDX_W-1:0] idx_o,
  output logic              any_req_o
);
  // Walk from farthest to nearest so the nearest requester overwrites the others
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = N; i >= 1; i--)
      for (int j = 0; j < N; j++)
        if (req_i[j] && j == (int'(last_i) + i) % N) begin
          gnt_o = N'(1) << j;
          idx_o = MIDX_W'(j);
        end
  end
  assign any_req_o = |req_i;
endmodule

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: round-robin Wishbone arbiter with cyc-lock and stall watchdog
module core_bus_arbiter
  import core_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_MASTERS-1:0]                  m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                  m_stb_i,
  input  logic [NUM_MASTERS-1:0]                  m_we_i,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]  m_addr_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  m_data_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] m_sel_i,
  output logic [DATA_WIDTH-1:0]                   m_data_o,
  output logic [NUM_MASTERS-1:0]                  m_ack_o,
  output logic [NUM_MASTERS-1:0]                  m_err_o,
  output logic                                    s_cyc_o,
  output logic                                    s_stb_o,
  output logic                                    s_we_o,
  output logic [ADDR_WIDTH-1:0]                   s_addr_o,
  output logic [DATA_WIDTH-1:0]                   s_data_o,
  output logic [DATA_WIDTH/8-1:0]                 s_sel_o,
  input  logic [DATA_WIDTH-1:0]                   s_data_i,
  input  logic                                    s_ack_i,
  output logic [NUM_MASTERS-1:0]                  grant_o,
  output logic                                    timeout_o
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  arb_state_t state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, rr_gnt;
  logic [MIDX_W-1:0] last_q, last_d, rr_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic any_req, busy;
  rr_arbiter #(.N(NUM_MASTERS)) u_rr (
    .req_i     (m_cyc_i & m_stb_i),
    .last_i    (last_q),
    .gnt_o     (rr_gnt),
    .idx_o     (rr_idx),
    .any_req_o (any_req)
  );
  assign busy      = state_q == BUSY;
  assign timeout_o = state_q == ABORT;
  assign grant_o   = grant_q;
  assign m_data_o  = s_data_i;
  assign m_ack_o   = (busy && s_ack_i) ? grant_q : '0;
  assign m_err_o   = timeout_o ? grant_q : '0;
  // grant_q is one-hot, so selecting by its set bit is a plain mux
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    s_sel_o  = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (busy && grant_q[i]) begin
        s_cyc_o  = m_cyc_i[i];
        s_stb_o  = m_stb_i[i];
        s_we_o   = m_we_i[i];
        s_addr_o = m_addr_i[i];
        s_data_o = m_data_i[i];
        s_sel_o  = m_sel_i[i];
      end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (any_req) begin
          state_d = BUSY;
          grant_d = rr_gnt;
          last_d  = rr_idx;
        end
      end
      BUSY: begin
        cnt_d = s_ack_i ? '0 : (s_stb_o && cnt_q != LIMIT) ? cnt_q + 1'b1 : cnt_q;
        if (!s_cyc_o) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (TIMEOUT_CYCLES != 0 && cnt_d == LIMIT) state_d = ABORT;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= MIDX_W'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: directed scenarios checked against a per-cycle ownership model
module tb_core_bus_arbiter;
  localparam int NM = 2, AW = 32, DW = 32, T = 8;
  logic clk = 0, rst_n = 0;
  logic [NM-1:0] m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
  logic [NM-1:0][AW-1:0] m_addr_i = '0;
  logic [NM-1:0][DW-1:0] m_data_i = '0;
  logic [NM-1:0][DW/8-1:0] m_sel_i = '0;
  logic [DW-1:0] m_data_o, s_data_o, s_data_i = '0;
  logic [NM-1:0] m_ack_o, m_err_o, grant_o;
  logic s_cyc_o, s_stb_o, s_we_o, s_ack_i = 0, timeout_o;
  logic [AW-1:0] s_addr_o;
  logic [DW/8-1:0] s_sel_o;
  int n_chk = 0, n_fail = 0;
  int owner = -1, last = NM - 1, stall = 0;
  bit aborting = 0;
  bit slave_on = 1, stray = 0;
  int ack_lat = 1, wcnt = 0;
  logic [31:0] rd_data = 0;
  string glog = "";
  logic [NM-1:0] prev_g = '0;
  int n_to = 0, bad_ack = 0;
  logic e_busy;

  core_bus_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_sel_i(m_sel_i), .m_data_o(m_data_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chks(input string nm, input string act, input string exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
    end
  endtask

  // Ownership model: who holds the bus, how long it has stalled, whether it is being aborted
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = -1; last = NM - 1; stall = 0; aborting = 0;
    end else if (aborting) begin
      aborting = 0; owner = -1;
    end else if (owner < 0) begin
      for (int i = 1; i <= NM; i++)
        if (owner < 0 && m_cyc_i[(last + i) % NM] && m_stb_i[(last + i) % NM]) begin
          owner = (last + i) % NM; stall = 0;
        end
      if (owner >= 0) last = owner;
    end else if (!m_cyc_i[owner]) owner = -1;
    else if (s_ack_i) stall = 0;
    else if (m_stb_i[owner]) begin
      if (stall < T) stall++;
      if (stall == T) aborting = 1;
    end
  end

  always @(negedge clk) begin
    e_busy = owner >= 0 && !aborting;
    chk("grant", grant_o, owner >= 0 ? NM'(1) << owner : '0);
    chk("s_cyc", s_cyc_o, e_busy ? m_cyc_i[owner] : 1'b0);
    chk("s_stb", s_stb_o, e_busy ? m_stb_i[owner] : 1'b0);
    chk("s_we", s_we_o, e_busy ? m_we_i[owner] : 1'b0);
    chk("s_addr", s_addr_o, e_busy ? m_addr_i[owner] : '0);
    chk("s_data", s_data_o, e_busy ? m_data_i[owner] : '0);
    chk("s_sel", s_sel_o, e_busy ? m_sel_i[owner] : '0);
    chk("m_ack", m_ack_o, (e_busy && s_ack_i) ? NM'(1) << owner : '0);
    chk("m_err", m_err_o, aborting ? NM'(1) << owner : '0);
    chk("timeout", timeout_o, aborting);
    chk("m_data", m_data_o, s_data_i);
    if (timeout_o) n_to++;
    if (m_ack_o[1] && grant_o[0]) bad_ack++;
    if (grant_o != 0 && prev_g == 0) glog = {glog, $sformatf("%0d", grant_o[1])};
    prev_g = grant_o;
  end

  // Slave: acks the (ack_lat+1)-th consecutive strobed cycle, one-cycle ack
  always @(posedge clk) begin
    #2;
    if (stray) begin
      s_ack_i = 1; stray = 0;
    end else if (s_ack_i) begin
      s_ack_i = 0; wcnt = 0;
    end else if (slave_on && s_cyc_o && s_stb_o) begin
      if (wcnt == ack_lat) begin
        s_ack_i = 1; s_data_i = rd_data;
      end else wcnt++;
    end else wcnt = 0;
  end

  task automatic txn(input int m, input bit we, input logic [31:0] a, input logic [31:0] d,
                     input bit keep, output logic [31:0] rdat);
    int n;
    m_cyc_i[m] = 1; m_stb_i[m] = 1; m_we_i[m] = we;
    m_addr_i[m] = a; m_data_i[m] = d; m_sel_i[m] = we ? 4'hc : 4'hf;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_ack_o[m] && n < 200);
    chk($sformatf("ack_arrived_m%0d", m), m_ack_o[m], 1'b1);
    rdat = m_data_o;
    @(posedge clk); #1;
    m_stb_i[m] = 0;
    if (!keep) m_cyc_i[m] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "bench hung");
  end

  initial begin
    logic [31:0] r0, r1;
    int n;
    @(negedge clk);
    chk("rst_grant", grant_o, 0); chk("rst_scyc", s_cyc_o, 0); chk("rst_ack", m_ack_o, 0);
    chk("rst_err", m_err_o, 0); chk("rst_timeout", timeout_o, 0);
    @(posedge clk); #1 rst_n = 1;
    // single master read
    @(posedge clk); #1;
    ack_lat = 2; rd_data = 32'hDEADBEEF;
    m_cyc_i[0] = 1; m_stb_i[0] = 1; m_we_i[0] = 0; m_addr_i[0] = 32'h100; m_sel_i[0] = 4'hf;
    @(negedge clk); chk("rd_idle_grant", grant_o, 2'b00);
    @(negedge clk); chk("rd_grant", grant_o, 2'b01); chk("rd_s_cyc", s_cyc_o, 1);
    chk("rd_s_addr", s_addr_o, 32'h100);
    @(negedge clk); chk("rd_no_ack_yet", m_ack_o, 2'b00);
    @(negedge clk); chk("rd_ack", m_ack_o, 2'b01); chk("rd_data", m_data_o, 32'hDEADBEEF);
    @(posedge clk); #1; m_cyc_i[0] = 0; m_stb_i[0] = 0;
    @(negedge clk); chk("rd_release_scyc", s_cyc_o, 0);
    @(negedge clk); chk("rd_idle", grant_o, 2'b00);
    // stray ack while idle
    @(posedge clk); stray = 1;
    @(negedge clk); chk("stray_ack", m_ack_o, 2'b00); chk("stray_grant", grant_o, 2'b00);
    // simultaneous writes from reset
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    ack_lat = 1; glog = "";
    fork
      txn(0, 1, 32'h200, 32'h11111111, 0, r0);
      txn(1, 1, 32'h300, 32'h22222222, 0, r1);
    join
    chks("simul_order", glog, "01");
    // fairness
    glog = "";
    fork
      begin repeat (3) begin @(posedge clk); #1; txn(0, 0, 32'h10, 0, 0, r0); end end
      begin repeat (3) begin @(posedge clk); #1; txn(1, 1, 32'h20, 32'h5a5a5a5a, 0, r1); end end
    join
    chks("fair_order", glog, "010101");
    // bus lock
    glog = "";
    fork
      begin
        @(posedge clk); #1; txn(1, 0, 32'h30, 0, 1, r1);
        @(posedge clk); #1; txn(1, 1, 32'h34, 32'hcafef00d, 1, r1);
        @(posedge clk); #1; txn(1, 0, 32'h38, 0, 0, r1);
      end
      begin repeat (3) @(posedge clk); #1; txn(0, 1, 32'h40, 32'h0badf00d, 0, r0); end
    join
    chks("lock_order", glog, "10");
    // watchdog abort
    slave_on = 0;
    @(posedge clk); #1;
    m_cyc_i[0] = 1; m_stb_i[0] = 1; m_we_i[0] = 0; m_addr_i[0] = 32'h400;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk); chk($sformatf("to_quiet_%0d", k), {m_err_o, timeout_o}, 0);
    end
    @(negedge clk);
    chk("to_pulse", timeout_o, 1); chk("to_err", m_err_o, 2'b01); chk("to_scyc", s_cyc_o, 0);
    @(posedge clk); #1; m_cyc_i[0] = 0; m_stb_i[0] = 0;
    @(negedge clk); chk("to_idle_grant", grant_o, 2'b00); chk("to_after", timeout_o, 0);
    // ack exactly at the limit cycle
    slave_on = 1; ack_lat = 7;
    @(posedge clk); #1;
    m_cyc_i[0] = 1; m_stb_i[0] = 1; m_addr_i[0] = 32'h500;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_ack_o[0] && n < 40);
    chk("late_ack_cycle", n, 9); chk("late_no_abort", timeout_o, 0);
    @(posedge clk); #1; m_cyc_i[0] = 0; m_stb_i[0] = 0;
    repeat (2) @(negedge clk);
    chk("late_no_abort_after", timeout_o, 0);
    // reset mid-burst
    slave_on = 0; glog = "";
    @(posedge clk); #1; m_cyc_i[0] = 1; m_stb_i[0] = 1; m_addr_i[0] = 32'h600;
    @(posedge clk); #1; m_cyc_i[1] = 1; m_stb_i[1] = 1; m_addr_i[1] = 32'h700;
    @(negedge clk); chk("mid_pre_grant", grant_o, 2'b01); chk("mid_pre_scyc", s_cyc_o, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("mid_rst_grant", grant_o, 0); chk("mid_rst_scyc", s_cyc_o, 0);
    chk("mid_rst_sstb", s_stb_o, 0); chk("mid_rst_saddr", s_addr_o, 0);
    chk("mid_rst_ack", m_ack_o, 0); chk("mid_rst_err", m_err_o, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); chk("post_rst_idle", grant_o, 2'b00);
    @(negedge clk); chk("post_rst_grant", grant_o, 2'b01);
    @(posedge clk); #1; m_cyc_i = '0; m_stb_i = '0;
    repeat (3) @(negedge clk);
    chks("rst_order", glog, "00");
    chk("timeout_pulses", n_to, 1);
    chk("no_cross_ack", bad_ack, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
